timer_counter: RTL and testbench

- 32-bit programmable down-counter timer with three bus-visible registers: CTRL, PRESET and COUNT.
- Attaches to the CPU's memory-mapped device bus: a word address selects the register, reads are combinational, and writes take effect on the clock edge.
- Mode 0 is a one-shot countdown that raises a level interrupt at zero. Mode 1 auto-reloads from PRESET and never interrupts.

---
 rtl/timer_counter.sv | 88 ++++++++
 tb/tb_timer_counter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// 32-bit programmable down-counter with CTRL/PRESET/COUNT bus registers.
// Mode 0 counts down once and raises a level irq at zero; mode 1 auto-reloads silently.
module timer_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:2]  add_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  logic [3:0]  ctrl_reg, ctrl_next;
  logic [31:0] preset_reg, preset_next;
  logic [31:0] count_reg, count_next;
  logic        load_pending_reg, load_pending_next;

  logic        en;
  logic        mode_reload;
  logic [31:0] load_value;

  assign en          = ctrl_reg[0];
  // Only MODE=01 reloads; MODE=1x falls back to one-shot behaviour.
  assign mode_reload = (ctrl_reg[2:1] == 2'b01);
  // A load consumes the first tick, so it lands one below PRESET.
  assign load_value  = (preset_reg == 32'd0) ? 32'd0 : preset_reg - 32'd1;

  always_comb begin
    ctrl_next         = ctrl_reg;
    preset_next       = preset_reg;
    count_next        = count_reg;
    load_pending_next = load_pending_reg;

    if (en) begin
      if (load_pending_reg) begin
        count_next        = load_value;
        load_pending_next = 1'b0;
      end else if (count_reg != 32'd0) begin
        count_next = count_reg - 32'd1;
      end else if (mode_reload) begin
        count_next = load_value;
      end
    end

    // A CTRL write overrides the pending-load clear so it re-arms for the next enabled edge.
    if (we_i) begin
      case (add_i)
        ADDR_CTRL: begin
          ctrl_next         = dat_i[3:0];
          load_pending_next = 1'b1;
        end
        ADDR_PRESET: preset_next = dat_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_reg         <= 4'd0;
      preset_reg       <= 32'd0;
      count_reg        <= 32'd0;
      load_pending_reg <= 1'b0;
    end else begin
      ctrl_reg         <= ctrl_next;
      preset_reg       <= preset_next;
      count_reg        <= count_next;
      load_pending_reg <= load_pending_next;
    end
  end

  always_comb begin
    dat_o = 32'd0;
    case (add_i)
      ADDR_CTRL:   dat_o = {28'd0, ctrl_reg};
      ADDR_PRESET: dat_o = preset_reg;
      ADDR_COUNT:  dat_o = count_reg;
      default:     dat_o = 32'd0;
    endcase
  end

  assign irq = ctrl_reg[3] & ~ctrl_reg[1] & (count_reg == 32'd0);

endmodule

// File: tb/tb_timer_counter.sv
// Randomised and directed bench for timer_counter against a behavioural register model.
module tb_timer_counter;

  logic        clk_i;
  logic        rst_i;
  logic        we_i;
  logic [3:2]  add_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        irq;

  int tests_run;
  int tests_failed;

  // Behavioural model of the bus-visible state.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_load;

  timer_counter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we_i  (we_i),
    .add_i (add_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .irq   (irq)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic model_reset();
    m_ctrl   = 4'd0;
    m_preset = 32'd0;
    m_count  = 32'd0;
    m_load   = 1'b0;
  endtask

  function automatic logic m_irq();
    return m_ctrl[3] && (m_ctrl[1] == 1'b0) && (m_count == 32'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the timer rules, evaluated on pre-edge state.
  task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] lv, next_count;
    logic        next_load;
    lv         = (m_preset == 0) ? 32'd0 : m_preset - 1;
    next_count = m_count;
    next_load  = m_load;
    if (m_ctrl[0]) begin
      if (m_load) begin
        next_count = lv;
        next_load  = 1'b0;
      end else if (m_count > 0) next_count = m_count - 1;
      else if (m_ctrl[2:1] == 2'b01) next_count = lv;
    end
    if (we && a == 2'd0) begin
      m_ctrl    = d[3:0];
      next_load = 1'b1;
    end else if (we && a == 2'd1) begin
      m_preset = d;
    end
    m_count = next_count;
    m_load  = next_load;
  endtask

  // Drive one bus cycle; returns at posedge+1 with we_i low.
  task automatic tick(input logic we, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    we_i  = we;
    add_i = a;
    dat_i = d;
    @(posedge clk_i);
    model_edge(we, a, d);
    #1;
    we_i = 1'b0;
    $display("[TB] t=%0t we=%0d add=%0d dat=%h -> ctrl=%h preset=%h count=%h irq=%0d",
             $time, we, a, d, m_ctrl, m_preset, m_count, m_irq());
  endtask

  task automatic rd(input logic [1:0] a);
    add_i = a;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #12;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0]);
      tests_run++;
      if (dat_o !== 32'd0) begin tests_failed++; $display("FAIL reset_read[%0d]: got %h want 0", a, dat_o); end
    end
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_readback();
    reset_dut();
    tick(1'b1, 2'd0, 32'h12345678);
    tick(1'b1, 2'd1, 32'h89abcdef);
    tick(1'b1, 2'd2, 32'habcdef34);
    rd(2'd0);
    tests_run++;
    if (dat_o !== 32'h8) begin tests_failed++; $display("FAIL rb_ctrl: got %h want 00000008", dat_o); end
    rd(2'd1);
    tests_run++;
    if (dat_o !== 32'h89abcdef) begin tests_failed++; $display("FAIL rb_preset: got %h want 89abcdef", dat_o); end
    rd(2'd2);
    tests_run++;
    if (dat_o !== 32'h0) begin tests_failed++; $display("FAIL rb_count: got %h want 0", dat_o); end
  endtask

  task automatic test_irq_gating();
    reset_dut();
    tick(1'b1, 2'd0, 32'h8);
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL gate_im_on: got %b want 1", irq); end
    tick(1'b1, 2'd0, 32'h0);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL gate_im_off: got %b want 0", irq); end
    tick(1'b1, 2'd1, 32'h87654321);
    rd(2'd2);
    tests_run++;
    if (dat_o !== 32'h0 || irq !== 1'b0) begin
      tests_failed++; $display("FAIL gate_preset: count %h irq %b want 0/0", dat_o, irq);
    end
    tick(1'b1, 2'd0, 32'h9);
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL gate_enable_irq: got %b want 1", irq); end
    tick(1'b0, 2'd2, 32'h0);
    tests_run++;
    if (dat_o !== 32'h87654320 || irq !== 1'b0) begin
      tests_failed++; $display("FAIL gate_load: count %h irq %b want 87654320/0", dat_o, irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_count [4];
    logic        exp_irq   [4];
    exp_count = '{32'd2, 32'd1, 32'd0, 32'd0};
    exp_irq   = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 2'd0, 32'h8);
      tests_run++;
      if (irq !== 1'b0) begin tests_failed++; $display("FAIL oneshot_im_nz[%0d]: got %b want 0", k, irq); end
    end
    tick(1'b1, 2'd1, 32'd3);
    tick(1'b1, 2'd0, 32'h9);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL oneshot_arm: got %b want 0", irq); end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 2'd2, 32'h0);
      tests_run++;
      if (dat_o !== exp_count[k] || irq !== exp_irq[k]) begin
        tests_failed++;
        $display("FAIL oneshot_seq[%0d]: count %h irq %b want %h/%b", k, dat_o, irq, exp_count[k], exp_irq[k]);
      end
    end
  endtask

  task automatic test_mode1_zero();
    reset_dut();
    tick(1'b1, 2'd0, 32'hB);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL m1z_arm: got %b want 0", irq); end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 2'd2, 32'h0);
      tests_run++;
      if (dat_o !== 32'd0 || irq !== 1'b0) begin
        tests_failed++; $display("FAIL m1z_hold[%0d]: count %h irq %b want 0/0", k, dat_o, irq);
      end
    end
  endtask

  task automatic test_mode1_reload();
    logic [31:0] exp_count [6];
    exp_count = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};
    reset_dut();
    tick(1'b1, 2'd0, 32'hA);
    tick(1'b1, 2'd1, 32'd3);
    tick(1'b1, 2'd0, 32'hB);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 2'd2, 32'h0);
      tests_run++;
      if (dat_o !== exp_count[k] || irq !== 1'b0) begin
        tests_failed++; $display("FAIL m1_reload[%0d]: count %h irq %b want %h/0", k, dat_o, irq, exp_count[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    tick(1'b1, 2'd1, 32'd10);
    tick(1'b1, 2'd0, 32'h9);
    for (int k = 0; k < 3; k++) tick(1'b0, 2'd2, 32'h0);
    #1;
    rst_i = 1'b1;
    #1;
    model_reset();
    for (int a = 0; a < 3; a++) begin
      add_i = a[1:0];
      #0.5;
      tests_run++;
      if (dat_o !== 32'd0) begin tests_failed++; $display("FAIL async_rst_read[%0d]: got %h want 0", a, dat_o); end
    end
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL async_rst_irq: got %b want 0", irq); end
    rst_i = 1'b0;
    tick(1'b1, 2'd1, 32'd5);
    tick(1'b0, 2'd2, 32'h0);
    tick(1'b0, 2'd2, 32'h0);
    tests_run++;
    if (dat_o !== 32'd0) begin tests_failed++; $display("FAIL async_no_resume: got %h want 0", dat_o); end
    tick(1'b1, 2'd0, 32'h1);
    tick(1'b0, 2'd2, 32'h0);
    tests_run++;
    if (dat_o !== 32'd4) begin tests_failed++; $display("FAIL async_resume: got %h want 4", dat_o); end
  endtask

  task automatic test_random();
    logic        we;
    logic [1:0]  a;
    logic [31:0] d;
    logic [1:0]  ra;
    reset_dut();
    for (int n = 0; n < 300; n++) begin
      we = ($urandom_range(0, 3) == 0);
      a  = 2'($urandom_range(0, 3));
      if (a == 2'd1) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
      else d = $urandom;
      tick(we, a, d);
      tests_run++;
      if (irq !== m_irq()) begin tests_failed++; $display("FAIL rand_irq[%0d]: got %b want %b", n, irq, m_irq()); end
      ra = 2'($urandom_range(0, 3));
      rd(ra);
      tests_run++;
      if (dat_o !== m_read(ra)) begin
        tests_failed++; $display("FAIL rand_read[%0d] add=%0d: got %h want %h", n, ra, dat_o, m_read(ra));
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    we_i  = 1'b0;
    add_i = 2'd0;
    dat_i = 32'd0;
    rst_i = 1'b1;
    model_reset();
    test_reset();
    test_readback();
    test_irq_gating();
    test_oneshot();
    test_mode1_zero();
    test_mode1_reload();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
